uart_fifo_ip: RTL

Next-generation memory-mapped UART for the RV32I SoC local bus, replacing the fixed-rate TX/RX peripheral. It adds parametrised TX and RX FIFOs, a run-time programmable baud divider, sticky error flags and a level interrupt. It sits on the same local bus (waddr/wdata/wen/wstrb/wready, raddr/ren/rdata/rvalid) as the other peripherals. Frame format is 8N1.

---
 rtl/uart_fifo_ip.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_ip.sv
// uart_fifo_ip: memory-mapped 8N1 UART with TX/RX FIFOs, programmable baud divider,
// sticky error flags and level irq. Define UART_PARITY_EN to add an optional parity bit.

module uart_fifo_ip_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          push_ok, pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rp];

  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= din;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0; rp <= '0; level <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module uart_fifo_ip #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STRB_W       = DATA_W/8,
  parameter int FIFO_DEPTH   = 8,
  parameter int DEF_BAUD_DIV = 234
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic [STRB_W-1:0] wstrb,
  output logic              wready,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              o_uart_tx,
  input  logic              i_uart_rx,
  output logic              o_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PAR = 3'd3;
`endif

  logic        ctrl_en, ctrl_rxie, ctrl_txie, ctrl_pen, ctrl_podd;
  logic [15:0] div, div_nx;
  logic        st_rxovr, st_ferr, st_perr, st_txdrop;
  logic        wr_ctrl, wr_stat, wr_tx, wr_baud, tx_flush, rx_flush;
  logic [7:0]  tx_dout, rx_dout;
  logic [AW:0] tx_lvl, rx_lvl;
  logic        tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_pop, rx_push;
  logic [2:0]  t_st, r_st, t_bit, r_bit;
  logic [15:0] t_cnt, r_cnt;
  logic [7:0]  t_sh, r_sh;
  logic        r_pbad, rx_s1, rx_s2, rx_d, r_samp;
  logic [31:0] stat, rd_mux;
  logic        unused_bits;

  assign unused_bits = ^{waddr[ADDR_W-1:5], waddr[1:0], raddr[ADDR_W-1:5], raddr[1:0],
                         wdata[DATA_W-1:16], wstrb[STRB_W-1:2]};
  assign wready   = 1'b1;
  assign wr_ctrl  = wen && waddr[4:2] == 3'd0 && wstrb[0];
  assign wr_stat  = wen && waddr[4:2] == 3'd1;
  assign wr_tx    = wen && waddr[4:2] == 3'd2 && wstrb[0];
  assign wr_baud  = wen && waddr[4:2] == 3'd4 && (wstrb[0] || wstrb[1]);
  assign tx_flush = wr_ctrl && wdata[1];
  assign rx_flush = wr_ctrl && wdata[2];
  assign rx_pop   = ren && raddr[4:2] == 3'd3 && !rx_empty;
  assign tx_pop   = ctrl_en && !tx_empty &&
                    (t_st == S_IDLE || (t_st == S_STOP && t_cnt == '0));
  assign r_samp   = ctrl_en && r_st == S_STOP && r_cnt == '0;
  assign rx_push  = r_samp && rx_s2 && !r_pbad;

  uart_fifo_ip_fifo #(.DEPTH(FIFO_DEPTH)) u_txf (
    .clk(clk), .rst(rst), .flush(tx_flush), .push(wr_tx), .din(wdata[7:0]), .pop(tx_pop),
    .dout(tx_dout), .level(tx_lvl), .full(tx_full), .empty(tx_empty));
  uart_fifo_ip_fifo #(.DEPTH(FIFO_DEPTH)) u_rxf (
    .clk(clk), .rst(rst), .flush(rx_flush), .push(rx_push), .din(r_sh), .pop(rx_pop),
    .dout(rx_dout), .level(rx_lvl), .full(rx_full), .empty(rx_empty));

  always_comb begin
    div_nx = div;
    if (wstrb[0]) div_nx[7:0]  = wdata[7:0];
    if (wstrb[1]) div_nx[15:8] = wdata[15:8];
    if (div_nx < 16'd4) div_nx = 16'd4;
  end

  // sticky flags: hardware set beats a same-cycle write-1-to-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en <= 1'b0; ctrl_rxie <= 1'b0; ctrl_txie <= 1'b0;
      div <= 16'(DEF_BAUD_DIV);
      st_rxovr <= 1'b0; st_ferr <= 1'b0; st_txdrop <= 1'b0;
      o_irq <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en <= wdata[0]; ctrl_rxie <= wdata[3]; ctrl_txie <= wdata[4];
      end
      if (wr_baud) div <= div_nx;
      st_rxovr  <= (st_rxovr  && !(wr_stat && wstrb[0] && wdata[5])) ||
                   (rx_push && rx_full && !rx_pop);
      st_ferr   <= (st_ferr   && !(wr_stat && wstrb[0] && wdata[6])) || (r_samp && !rx_s2);
      st_txdrop <= (st_txdrop && !(wr_stat && wstrb[1] && wdata[8])) ||
                   (wr_tx && tx_full && !tx_pop && !tx_flush);
      o_irq <= (ctrl_rxie && !rx_empty) || (ctrl_txie && tx_empty);
    end
  end

`ifdef UART_PARITY_EN
  logic t_par;
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_pen <= 1'b0; ctrl_podd <= 1'b0; st_perr <= 1'b0; t_par <= 1'b0; r_pbad <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_pen <= wdata[5]; ctrl_podd <= wdata[6];
      end
      st_perr <= (st_perr && !(wr_stat && wstrb[0] && wdata[7])) || (r_samp && rx_s2 && r_pbad);
      if (tx_pop) t_par <= ^tx_dout ^ ctrl_podd;
      if (r_st == S_IDLE) r_pbad <= 1'b0;
      else if (r_st == S_PAR && r_cnt == '0) r_pbad <= rx_s2 != (^r_sh ^ ctrl_podd);
    end
  end
`else
  assign ctrl_pen  = 1'b0;
  assign ctrl_podd = 1'b0;
  assign st_perr   = 1'b0;
  assign r_pbad    = 1'b0;
`endif

  // TX: each state holds for div clocks; div is re-read at every bit boundary
  always_ff @(posedge clk) begin
    if (rst || !ctrl_en) begin
      t_st <= S_IDLE; t_cnt <= '0; t_bit <= '0; t_sh <= '0;
    end else if (t_st == S_IDLE || (t_st == S_STOP && t_cnt == '0)) begin
      if (tx_pop) begin
        t_st <= S_START; t_cnt <= div - 16'd1; t_sh <= tx_dout; t_bit <= '0;
      end else t_st <= S_IDLE;
    end else if (t_cnt != '0) t_cnt <= t_cnt - 16'd1;
    else begin
      t_cnt <= div - 16'd1;
      case (t_st)
        S_START: t_st <= S_DATA;
        S_DATA:
          if (t_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            t_st <= ctrl_pen ? S_PAR : S_STOP;
`else
            t_st <= S_STOP;
`endif
          end else begin
            t_bit <= t_bit + 3'd1; t_sh <= t_sh >> 1;
          end
        default: t_st <= S_STOP;
      endcase
    end
  end

  always_comb begin
    o_uart_tx = 1'b1;
    if (ctrl_en)
      case (t_st)
        S_START: o_uart_tx = 1'b0;
        S_DATA:  o_uart_tx = t_sh[0];
`ifdef UART_PARITY_EN
        S_PAR:   o_uart_tx = t_par;
`endif
        default: o_uart_tx = 1'b1;
      endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_d <= 1'b1;
    end else begin
      rx_s1 <= i_uart_rx; rx_s2 <= rx_s1; rx_d <= rx_s2;
    end
  end

  // RX: first sample at half a bit after the falling edge, then every div clocks
  always_ff @(posedge clk) begin
    if (rst || !ctrl_en) begin
      r_st <= S_IDLE; r_cnt <= '0; r_bit <= '0; r_sh <= '0;
    end else if (r_st == S_IDLE) begin
      if (rx_d && !rx_s2) begin
        r_st <= S_START; r_cnt <= {1'b0, div[15:1]} - 16'd1;
      end
    end else if (r_cnt != '0) r_cnt <= r_cnt - 16'd1;
    else begin
      r_cnt <= div - 16'd1;
      case (r_st)
        S_START: begin r_st <= rx_s2 ? S_IDLE : S_DATA; r_bit <= '0; end
        S_DATA: begin
          r_sh <= {rx_s2, r_sh[7:1]}; r_bit <= r_bit + 3'd1;
          if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            r_st <= ctrl_pen ? S_PAR : S_STOP;
`else
            r_st <= S_STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        S_PAR:   r_st <= S_STOP;
`endif
        default: r_st <= S_IDLE;
      endcase
    end
  end

  assign stat = {8'(rx_lvl), 8'(tx_lvl), 7'd0, st_txdrop, st_perr, st_ferr, st_rxovr,
                 rx_full, !rx_empty, t_st != S_IDLE, tx_empty, tx_full};

  always_comb begin
    rd_mux = '0;
    case (raddr[4:2])
      3'd0:    rd_mux[6:0] = {ctrl_podd, ctrl_pen, ctrl_txie, ctrl_rxie, 2'b00, ctrl_en};
      3'd1:    rd_mux = stat;
      3'd3:    rd_mux[7:0] = rx_empty ? 8'h00 : rx_dout;
      3'd4:    rd_mux[15:0] = div;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0; rvalid <= 1'b0;
    end else begin
      rvalid <= ren;
      rdata  <= ren ? DATA_W'(rd_mux) : '0;
    end
  end
endmodule
